// File: rtl/lh_pkg.sv
// -----------------------------------------------------------------------------
// lh_pkg
// Shared definitions for the LightHouse sweep collector:
//   - sweep word layout (32-bit tick count + 2-bit axis address)
//   - axis encoding (LH0 axis0/1, LH1 axis0/1)
//   - output FSM state encoding
//   - DROP_COUNT width, default channel count, saturating add helper
// -----------------------------------------------------------------------------
package lh_pkg;

  localparam int TICK_W        = 32;
  localparam int AXIS_W        = 2;
  localparam int DROP_CNT_W    = 16;
  localparam int N_SENSORS_DEF = 4;

  typedef enum logic [AXIS_W-1:0] {
    AXIS_LH0_A0 = 2'd0,
    AXIS_LH0_A1 = 2'd1,
    AXIS_LH1_A0 = 2'd2,
    AXIS_LH1_A1 = 2'd3
  } lh_axis_e;

  typedef struct packed {
    logic [TICK_W-1:0] ticks;
    logic [AXIS_W-1:0] axis;
  } lh_sweep_t;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } lh_out_state_e;

  // Saturating add used by the drop counter; sticks at all-ones.
  function automatic logic [DROP_CNT_W-1:0] sat_add_cnt(
    input logic [DROP_CNT_W-1:0] a,
    input logic [DROP_CNT_W-1:0] b
  );
    logic [DROP_CNT_W:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    if (sum[DROP_CNT_W]) begin
      return {DROP_CNT_W{1'b1}};
    end else begin
      return sum[DROP_CNT_W-1:0];
    end
  endfunction

endpackage

// File: rtl/lh_sweep_arbiter_if.sv
// -----------------------------------------------------------------------------
// lh_sweep_arbiter_if
// Host-facing valid/ready channel carrying one sweep result.
//   valid  : word valid (driven by collector)
//   ready  : consumer accepts word (driven by host serializer)
//   data   : 32-bit tick value
//   addr   : 2-bit axis address
//   sensor : originating channel index
// master = collector side, slave = consumer side.
// -----------------------------------------------------------------------------
interface lh_sweep_arbiter_if #(
  parameter int IDX_W = 4
) ();
  import lh_pkg::*;

  logic              valid;
  logic              ready;
  logic [TICK_W-1:0] data;
  logic [AXIS_W-1:0] addr;
  logic [IDX_W-1:0]  sensor;

  modport master (output valid, output data, output addr, output sensor, input  ready);
  modport slave  (input  valid, input  data, input  addr, input  sensor, output ready);

endinterface

// File: rtl/lh_rr_arbiter.sv
// -----------------------------------------------------------------------------
// lh_rr_arbiter
// Combinational N-way round-robin pick. Scans from i_ptr+1 upward (mod N)
// and grants the first set request bit.
//   i_req : request vector
//   i_ptr : index of the previous winner
//   o_gnt : one-hot grant (zero when no request)
//   o_idx : encoded index of the winner
//   o_any : at least one request set
// -----------------------------------------------------------------------------
module lh_rr_arbiter #(
  parameter int N     = 4,
  parameter int IDX_W = 4
) (
  input  logic [N-1:0]     i_req,
  input  logic [IDX_W-1:0] i_ptr,
  output logic [N-1:0]     o_gnt,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_any
);

  localparam int SEL_W = (N > 1) ? $clog2(N) : 1;

  logic [SEL_W-1:0] w_cand;

  // Rotating priority scan starting just after the last winner.
  always_comb begin
    o_gnt  = '0;
    o_idx  = '0;
    o_any  = 1'b0;
    w_cand = '0;
    for (int k = 1; k <= N; k++) begin
      w_cand = SEL_W'((int'(i_ptr) + k) % N);
      if (!o_any && i_req[w_cand]) begin
        o_any         = 1'b1;
        o_gnt[w_cand] = 1'b1;
        o_idx         = IDX_W'(w_cand);
      end else begin
        o_any = o_any;
      end
    end
  end

endmodule

// File: rtl/lh_sweep_arbiter.sv
// -----------------------------------------------------------------------------
// lh_sweep_arbiter
// Collects single-cycle sweep results from N decoders into one-deep slots,
// round-robins among pending slots and presents one word at a time on a
// valid/ready channel. Tracks dropped results per channel and in total.
//   CLK, RST_N   : clock, asynchronous active-low reset
//   ENABLE       : per-channel enable (0 flushes the slot, ignores strobes)
//   SENS_READY   : per-channel one-cycle result strobe
//   SENS_DATA    : tick values, channel i at [32i+31:32i]
//   SENS_ADDR    : axis addresses, channel i at [2i+1:2i]
//   out_if       : host channel (valid/ready/data/addr/sensor)
//   OVERFLOW     : sticky per-channel drop flags
//   CLR_OVF      : clears OVERFLOW and DROP_COUNT (a same-cycle drop wins)
//   DROP_COUNT   : saturating total of dropped results
// -----------------------------------------------------------------------------
module lh_sweep_arbiter
  import lh_pkg::*;
#(
  parameter int N_SENSORS = N_SENSORS_DEF,
  parameter int IDX_W     = 4
) (
  input  logic                      CLK,
  input  logic                      RST_N,
  input  logic [N_SENSORS-1:0]      ENABLE,
  input  logic [N_SENSORS-1:0]      SENS_READY,
  input  logic [TICK_W*N_SENSORS-1:0] SENS_DATA,
  input  logic [AXIS_W*N_SENSORS-1:0] SENS_ADDR,
  lh_sweep_arbiter_if.master        out_if,
  output logic [N_SENSORS-1:0]      OVERFLOW,
  input  logic                      CLR_OVF,
  output logic [DROP_CNT_W-1:0]     DROP_COUNT
);

  lh_out_state_e            r_state;
  lh_out_state_e            w_state_nxt;
  lh_sweep_t                r_slot [N_SENSORS];
  logic [N_SENSORS-1:0]     r_pending;
  logic [IDX_W-1:0]         r_rr_ptr;
  lh_sweep_t                r_out;
  logic [IDX_W-1:0]         r_out_sensor;
  logic [N_SENSORS-1:0]     r_overflow;
  logic [DROP_CNT_W-1:0]    r_drop_cnt;

  logic [N_SENSORS-1:0]     w_req;
  logic [N_SENSORS-1:0]     w_gnt;
  logic [IDX_W-1:0]         w_idx;
  logic                     w_any;
  logic                     w_hs;
  logic                     w_grant_en;
  logic                     w_do_grant;
  logic [N_SENSORS-1:0]     w_granted;
  logic [N_SENSORS-1:0]     w_strobe;
  logic [N_SENSORS-1:0]     w_capture;
  logic [N_SENSORS-1:0]     w_drop;
  logic [N_SENSORS-1:0]     w_pending_nxt;
  logic [N_SENSORS-1:0]     w_overflow_nxt;
  logic [DROP_CNT_W-1:0]    w_drop_num;
  logic [DROP_CNT_W-1:0]    w_drop_cnt_nxt;
  lh_sweep_t                w_sel;

  // Disabled channels are masked so a slot being flushed can never win.
  assign w_req = r_pending & ENABLE;

  lh_rr_arbiter #(
    .N     (N_SENSORS),
    .IDX_W (IDX_W)
  ) u_rr (
    .i_req (w_req),
    .i_ptr (r_rr_ptr),
    .o_gnt (w_gnt),
    .o_idx (w_idx),
    .o_any (w_any)
  );

  assign w_hs       = (r_state == ST_FULL) & out_if.ready;
  assign w_grant_en = (r_state == ST_EMPTY) | w_hs;
  assign w_do_grant = w_grant_en & w_any;
  assign w_granted  = w_do_grant ? w_gnt : '0;
  assign w_strobe   = SENS_READY & ENABLE;

  // A slot being granted this cycle is free for a new capture in the same cycle.
  assign w_capture     = w_strobe & (~r_pending | w_granted);
  assign w_drop        = w_strobe & r_pending & ~w_granted;
  assign w_pending_nxt = ENABLE & (w_capture | (r_pending & ~w_granted));

  // Drop accounting: popcount of this cycle's drops, clear applied first so drops win.
  always_comb begin
    w_drop_num = '0;
    for (int i = 0; i < N_SENSORS; i++) begin
      w_drop_num = w_drop_num + {{(DROP_CNT_W-1){1'b0}}, w_drop[i]};
    end
    if (CLR_OVF) begin
      w_overflow_nxt = w_drop;
      w_drop_cnt_nxt = w_drop_num;
    end else begin
      w_overflow_nxt = r_overflow | w_drop;
      w_drop_cnt_nxt = sat_add_cnt(r_drop_cnt, w_drop_num);
    end
  end

  // One-hot mux of the winning slot.
  always_comb begin
    w_sel = '0;
    for (int i = 0; i < N_SENSORS; i++) begin
      if (w_gnt[i]) begin
        w_sel = w_sel | r_slot[i];
      end else begin
        w_sel = w_sel;
      end
    end
  end

  // Output FSM next-state.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_EMPTY: begin
        if (w_any) begin
          w_state_nxt = ST_FULL;
        end else begin
          w_state_nxt = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (w_hs && !w_any) begin
          w_state_nxt = ST_EMPTY;
        end else begin
          w_state_nxt = ST_FULL;
        end
      end
      default: w_state_nxt = ST_EMPTY;
    endcase
  end

  // Output FSM state register.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state <= ST_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Per-channel slot capture and pending bits.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_pending <= '0;
      for (int i = 0; i < N_SENSORS; i++) begin
        r_slot[i] <= '0;
      end
    end else begin
      r_pending <= w_pending_nxt;
      for (int i = 0; i < N_SENSORS; i++) begin
        if (w_capture[i]) begin
          r_slot[i].ticks <= SENS_DATA[TICK_W*i +: TICK_W];
          r_slot[i].axis  <= SENS_ADDR[AXIS_W*i +: AXIS_W];
        end
      end
    end
  end

  // Output word register and round-robin pointer; load only on grant.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_out        <= '0;
      r_out_sensor <= '0;
      r_rr_ptr     <= IDX_W'(N_SENSORS - 1);
    end else if (w_do_grant) begin
      r_out        <= w_sel;
      r_out_sensor <= w_idx;
      r_rr_ptr     <= w_idx;
    end
  end

  // Sticky overflow flags and saturating drop counter.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_overflow <= '0;
      r_drop_cnt <= '0;
    end else begin
      r_overflow <= w_overflow_nxt;
      r_drop_cnt <= w_drop_cnt_nxt;
    end
  end

  assign out_if.valid  = (r_state == ST_FULL);
  assign out_if.data   = r_out.ticks;
  assign out_if.addr   = r_out.axis;
  assign out_if.sensor = r_out_sensor;
  assign OVERFLOW      = r_overflow;
  assign DROP_COUNT    = r_drop_cnt;

endmodule

// File: tb/tb_lh_sweep_arbiter.sv
// -----------------------------------------------------------------------------
// tb_lh_sweep_arbiter
// Directed self-checking bench for lh_sweep_arbiter (N_SENSORS=4).
// -----------------------------------------------------------------------------
module tb_lh_sweep_arbiter;
  import lh_pkg::*;

  localparam int N  = 4;
  localparam int IW = 4;

  logic            CLK = 1'b0;
  logic            RST_N;
  logic [N-1:0]    ENABLE;
  logic [N-1:0]    SENS_READY;
  logic [32*N-1:0] SENS_DATA;
  logic [2*N-1:0]  SENS_ADDR;
  logic [N-1:0]    OVERFLOW;
  logic            CLR_OVF;
  logic [15:0]     DROP_COUNT;

  int total = 0;
  int bad   = 0;

  lh_sweep_arbiter_if #(.IDX_W(IW)) out_if ();

  lh_sweep_arbiter #(.N_SENSORS(N), .IDX_W(IW)) dut (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .ENABLE     (ENABLE),
    .SENS_READY (SENS_READY),
    .SENS_DATA  (SENS_DATA),
    .SENS_ADDR  (SENS_ADDR),
    .out_if     (out_if),
    .OVERFLOW   (OVERFLOW),
    .CLR_OVF    (CLR_OVF),
    .DROP_COUNT (DROP_COUNT)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic strobe(input int ch, input logic [31:0] d, input logic [1:0] a);
    SENS_READY[ch]         = 1'b1;
    SENS_DATA[32*ch +: 32] = d;
    SENS_ADDR[2*ch +: 2]   = a;
  endtask

  // Advance one edge, settle, then drop the one-cycle pulses.
  task automatic tick();
    @(posedge CLK);
    #1;
    SENS_READY = '0;
    CLR_OVF    = 1'b0;
  endtask

  task automatic do_reset();
    RST_N = 1'b0;
    @(posedge CLK);
    #1;
    RST_N = 1'b1;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    ENABLE       = '1;
    SENS_READY   = '0;
    SENS_DATA    = '0;
    SENS_ADDR    = '0;
    CLR_OVF      = 1'b0;
    out_if.ready = 1'b1;
    RST_N        = 1'b0;
    #12;
    chk("rst_valid", {31'd0, out_if.valid}, 32'd0);
    chk("rst_data", out_if.data, 32'd0);
    chk("rst_addr", {30'd0, out_if.addr}, 32'd0);
    chk("rst_sensor", {28'd0, out_if.sensor}, 32'd0);
    chk("rst_ovf", {28'd0, OVERFLOW}, 32'd0);
    chk("rst_drop", {16'd0, DROP_COUNT}, 32'd0);
    do_reset();

    // Single strobe on ch2.
    strobe(2, 32'h0000_1234, 2'd1);
    tick();
    chk("single_lat0", {31'd0, out_if.valid}, 32'd0);
    tick();
    chk("single_valid", {31'd0, out_if.valid}, 32'd1);
    chk("single_data", out_if.data, 32'h1234);
    chk("single_addr", {30'd0, out_if.addr}, 32'd1);
    chk("single_sensor", {28'd0, out_if.sensor}, 32'd2);
    tick();
    chk("single_done", {31'd0, out_if.valid}, 32'd0);

    // Simultaneous bursts from reset: order 0,1,2,3 twice.
    do_reset();
    for (int b = 0; b < 2; b++) begin
      for (int c = 0; c < N; c++) strobe(c, 32'h100 + 32'(c) + 32'(b * 16), 2'(c));
      tick();
      for (int c = 0; c < N; c++) begin
        tick();
        chk("burst_valid", {31'd0, out_if.valid}, 32'd1);
        chk("burst_sensor", {28'd0, out_if.sensor}, 32'(c));
        chk("burst_data", out_if.data, 32'h100 + 32'(c) + 32'(b * 16));
        chk("burst_addr", {30'd0, out_if.addr}, 32'(c));
      end
      tick();
      chk("burst_end", {31'd0, out_if.valid}, 32'd0);
    end

    // Backpressure with a drop on ch1.
    out_if.ready = 1'b0;
    strobe(1, 32'hAA, 2'd2);
    tick();
    tick();
    for (int c = 0; c < 10; c++) begin
      if (c == 2) strobe(1, 32'hBB, 2'd3);
      if (c == 4) strobe(1, 32'hCC, 2'd0);
      tick();
      chk("stall_valid", {31'd0, out_if.valid}, 32'd1);
      chk("stall_data", out_if.data, 32'hAA);
      chk("stall_addr", {30'd0, out_if.addr}, 32'd2);
      chk("stall_sensor", {28'd0, out_if.sensor}, 32'd1);
    end
    chk("stall_ovf", {28'd0, OVERFLOW}, 32'h2);
    chk("stall_drop", {16'd0, DROP_COUNT}, 32'd1);
    out_if.ready = 1'b1;
    tick();
    chk("stall_next_data", out_if.data, 32'hBB);
    chk("stall_next_sensor", {28'd0, out_if.sensor}, 32'd1);
    tick();
    chk("stall_empty", {31'd0, out_if.valid}, 32'd0);

    // Same-cycle grant and capture on ch0.
    out_if.ready = 1'b0;
    strobe(2, 32'h22, 2'd0);
    tick();
    tick();
    strobe(0, 32'h44, 2'd1);
    tick();
    out_if.ready = 1'b1;
    strobe(0, 32'h55, 2'd2);
    tick();
    chk("same_old_data", out_if.data, 32'h44);
    chk("same_old_sensor", {28'd0, out_if.sensor}, 32'd0);
    chk("same_no_drop", {16'd0, DROP_COUNT}, 32'd1);
    tick();
    chk("same_new_valid", {31'd0, out_if.valid}, 32'd1);
    chk("same_new_data", out_if.data, 32'h55);
    chk("same_new_addr", {30'd0, out_if.addr}, 32'd2);
    tick();
    chk("same_empty", {31'd0, out_if.valid}, 32'd0);

    // Drops to 5, clear, then clear colliding with a drop.
    out_if.ready = 1'b0;
    strobe(3, 32'h33, 2'd3);
    tick();
    tick();
    strobe(3, 32'h34, 2'd3);
    tick();
    for (int c = 0; c < 4; c++) begin
      strobe(3, 32'h99, 2'd0);
      tick();
    end
    chk("drop5_cnt", {16'd0, DROP_COUNT}, 32'd5);
    chk("drop5_ovf", {28'd0, OVERFLOW}, 32'hA);
    CLR_OVF = 1'b1;
    tick();
    chk("clr_ovf", {28'd0, OVERFLOW}, 32'd0);
    chk("clr_cnt", {16'd0, DROP_COUNT}, 32'd0);
    CLR_OVF = 1'b1;
    strobe(3, 32'h98, 2'd0);
    tick();
    chk("clrdrop_ovf", {28'd0, OVERFLOW}, 32'h8);
    chk("clrdrop_cnt", {16'd0, DROP_COUNT}, 32'd1);

    // Saturation: count is 1, each cycle adds one drop.
    for (int c = 0; c < 65533; c++) begin
      strobe(3, 32'h97, 2'd0);
      tick();
    end
    chk("sat_pre", {16'd0, DROP_COUNT}, 32'hFFFE);
    for (int c = 0; c < 70000 - 65533; c++) begin
      strobe(3, 32'h97, 2'd0);
      tick();
    end
    chk("sat_cnt", {16'd0, DROP_COUNT}, 32'hFFFF);
    chk("sat_hold_data", out_if.data, 32'h33);

    // Async reset mid-stall with slots pending.
    strobe(0, 32'h1, 2'd0);
    strobe(1, 32'h2, 2'd0);
    strobe(2, 32'h3, 2'd0);
    tick();
    #2;
    RST_N = 1'b0;
    #1;
    chk("arst_valid", {31'd0, out_if.valid}, 32'd0);
    chk("arst_data", out_if.data, 32'd0);
    chk("arst_cnt", {16'd0, DROP_COUNT}, 32'd0);
    @(posedge CLK);
    #1;
    RST_N = 1'b1;
    out_if.ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("arst_idle", {31'd0, out_if.valid}, 32'd0);
    end

    // ENABLE[3]=0 flushes pending ch3 and ignores its strobes.
    out_if.ready = 1'b0;
    strobe(0, 32'hA0, 2'd0);
    strobe(3, 32'hD3, 2'd1);
    tick();
    tick();
    chk("en_first_sensor", {28'd0, out_if.sensor}, 32'd0);
    ENABLE       = 4'b0111;
    out_if.ready = 1'b1;
    tick();
    chk("en_flushed", {31'd0, out_if.valid}, 32'd0);
    strobe(3, 32'hD4, 2'd1);
    tick();
    ENABLE = 4'b1111;
    tick();
    chk("en_ignored", {31'd0, out_if.valid}, 32'd0);
    chk("en_no_drop", {16'd0, DROP_COUNT}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
